// File: rtl/doc_pkg.sv
// Shared constants and FSM state type for the document-to-UART dump path.
package doc_pkg;

  localparam int         DOC_ADDR_W  = 9;
  localparam int         DOC_DEPTH   = 512;
  localparam int         DOC_ROW_LEN = 32;
  localparam logic [7:0] CHAR_NL     = 8'h0A;
  localparam logic [7:0] CHAR_SPACE  = 8'h20;

  typedef enum logic [2:0] {IDLE, RD, TX, NL, FIN} doc_state_t;

  // Empty RAM cells print as a visible filler instead of a NUL byte.
  function automatic logic [7:0] fill_map(input logic [7:0] b, input logic [7:0] fill);
    return (b == 8'h00) ? fill : b;
  endfunction

endpackage

// File: rtl/doc_port_mux.sv
// Editor-priority mux for the document RAM's single port; rd_grant tells the
// scheduler its read address actually reached the RAM this cycle.
module doc_port_mux
  import doc_pkg::*;
#(
  parameter int ADDR_W = DOC_ADDR_W
) (
  input  logic              ed_we,
  input  logic [ADDR_W-1:0] ed_addr,
  input  logic [7:0]        ed_wdata,
  input  logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              rd_grant
);

  always_comb begin
    mem_addr  = rd_ptr;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    rd_grant  = 1'b1;
    if (ed_we) begin
      mem_addr  = ed_addr;
      mem_we    = 1'b1;
      mem_wdata = ed_wdata;
      rd_grant  = 1'b0;
    end
  end

endmodule

// File: rtl/doc_tx_scheduler.sv
// Dumps the document RAM byte by byte to the UART TX on a start pulse.
// Define ROW_NEWLINE_EN to insert 8'h0A after the last byte of every text row.
module doc_tx_scheduler
  import doc_pkg::*;
#(
  parameter int         ADDR_W    = DOC_ADDR_W,
  parameter int         DEPTH     = DOC_DEPTH,
  parameter int         ROW_LEN   = DOC_ROW_LEN,
  parameter logic [7:0] FILL_CHAR = CHAR_SPACE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ed_we,
  input  logic [ADDR_W-1:0] ed_addr,
  input  logic [7:0]        ed_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

`ifdef ROW_NEWLINE_EN
  localparam bit NL_EN = 1'b1;
`else
  localparam bit NL_EN = 1'b0;
`endif

  localparam int                  ROW_BITS  = $clog2(ROW_LEN);
  localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST  = ROW_BITS'(ROW_LEN - 1);

  doc_state_t        state, state_n;
  logic [ADDR_W-1:0] rd_ptr, rd_ptr_n;
  logic [7:0]        tx_data_n;
  logic              tx_valid_n;
  logic              rd_grant;
  logic              hs;
  logic              last_byte;
  logic              row_end;

  doc_port_mux #(.ADDR_W(ADDR_W)) u_port_mux (
    .ed_we     (ed_we),
    .ed_addr   (ed_addr),
    .ed_wdata  (ed_wdata),
    .rd_ptr    (rd_ptr),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .rd_grant  (rd_grant)
  );

  assign hs        = tx_valid & tx_ready;
  assign last_byte = (rd_ptr == LAST_ADDR);
  assign row_end   = NL_EN && (rd_ptr[ROW_BITS-1:0] == ROW_LAST);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  // A read only counts in a cycle the editor left the port alone.
  always_comb begin
    state_n    = state;
    rd_ptr_n   = rd_ptr;
    tx_data_n  = tx_data;
    tx_valid_n = tx_valid;
    case (state)
      IDLE: begin
        if (start) begin
          rd_ptr_n = '0;
          state_n  = RD;
        end
      end
      RD: begin
        if (rd_grant) begin
          tx_data_n  = fill_map(mem_rdata, FILL_CHAR);
          tx_valid_n = 1'b1;
          state_n    = TX;
        end
      end
      TX: begin
        if (hs) begin
          tx_valid_n = 1'b0;
          if (row_end) begin
            tx_data_n  = CHAR_NL;
            tx_valid_n = 1'b1;
            state_n    = NL;
          end else if (last_byte) begin
            state_n = FIN;
          end else begin
            rd_ptr_n = rd_ptr + 1'b1;
            state_n  = RD;
          end
        end
      end
`ifdef ROW_NEWLINE_EN
      NL: begin
        if (hs) begin
          tx_valid_n = 1'b0;
          if (last_byte) begin
            state_n = FIN;
          end else begin
            rd_ptr_n = rd_ptr + 1'b1;
            state_n  = RD;
          end
        end
      end
`endif
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      state    <= state_n;
      rd_ptr   <= rd_ptr_n;
      tx_data  <= tx_data_n;
      tx_valid <= tx_valid_n;
    end
  end

endmodule

// File: tb/tb_doc_tx_scheduler.sv
// Self-checking bench for doc_tx_scheduler at default parameters; the expected
// byte stream follows ROW_NEWLINE_EN when the build defines it.
module tb_doc_tx_scheduler;

  localparam int         ADDR_W  = 9;
  localparam int         DEPTH   = 512;
  localparam int         ROW_LEN = 32;
  localparam logic [7:0] FILL    = 8'h20;
`ifdef ROW_NEWLINE_EN
  localparam bit NL_ON = 1'b1;
`else
  localparam bit NL_ON = 1'b0;
`endif

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_we;
    logic [7:0]        exp_wdata;
  } mux_vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              ed_we;
  logic [ADDR_W-1:0] ed_addr;
  logic [7:0]        ed_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done;

  logic [7:0] ram     [DEPTH];
  logic [7:0] exp_mem [DEPTH];

  doc_tx_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ed_we     (ed_we),
    .ed_addr   (ed_addr),
    .ed_wdata  (ed_wdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshake / done / stability monitor, sampled on the falling edge.
  logic [7:0] rx_q[$];
  int         rx_cyc_q[$];
  int         done_cnt     = 0;
  int         done_cyc     = -1;
  int         overlap_cnt  = 0;
  int         unstable_cnt = 0;
  logic       prev_stall   = 1'b0;
  logic [7:0] prev_data    = 8'h00;

  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      rx_q.push_back(tx_data);
      rx_cyc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (done && tx_valid) overlap_cnt <= overlap_cnt + 1;
    if (prev_stall && !rst && (!tx_valid || tx_data != prev_data))
      unstable_cnt <= unstable_cnt + 1;
    prev_stall <= tx_valid && !tx_ready && !rst;
    prev_data  <= tx_data;
  end

  int n_cmp  = 0;
  int n_fail = 0;
  bit rand_ready = 1'b0;
  int base_rx    = 0;
  int base_done  = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  // One clock: the RAM model takes the DUT's port write at the rising edge.
  task automatic tick();
    logic              we_s;
    logic [ADDR_W-1:0] a_s;
    logic [7:0]        d_s;
    @(negedge clk);
    we_s = mem_we;
    a_s  = mem_addr;
    d_s  = mem_wdata;
    @(posedge clk);
    if (we_s) ram[a_s] = d_s;
    #1;
    if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic applyStimulus(input mux_vec_t v, input int idx);
    ed_we    = v.we;
    ed_addr  = v.addr;
    ed_wdata = v.wdata;
    #1;
    checkOutput($sformatf("mux%0d_addr", idx), mem_addr, v.exp_addr);
    checkOutput($sformatf("mux%0d_we", idx), mem_we, v.exp_we);
    checkOutput($sformatf("mux%0d_wdata", idx), mem_wdata, v.exp_wdata);
  endtask

  function automatic int sent_addrs(input int k);
    return NL_ON ? k - k / (ROW_LEN + 1) : k;
  endfunction

  task automatic start_dump();
    for (int a = 0; a < DEPTH; a++) exp_mem[a] = ram[a];
    base_rx   = rx_q.size();
    base_done = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!tx_valid && n < budget) begin
      tick();
      n++;
    end
    checkOutput({name, "_valid_seen"}, tx_valid, 1);
  endtask

  task automatic run_to_done(input string name, input int budget, input bit rand_wr);
    int n = 0;
    int a;
    int sent;
    while (done_cnt == base_done && n < budget) begin
      ed_we = 1'b0;
      if (rand_wr && $urandom_range(0, 3) == 0) begin
        a    = $urandom_range(0, DEPTH - 1);
        sent = sent_addrs(rx_q.size() - base_rx);
        if (a >= sent + 4 || a + 3 < sent) begin
          ed_we    = 1'b1;
          ed_addr  = ADDR_W'(a);
          ed_wdata = 8'($urandom_range(0, 255));
          if (a >= sent + 4) exp_mem[a] = ed_wdata;
        end
      end
      tick();
      n++;
    end
    ed_we = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checkOutput({name, "_done_pulses"}, done_cnt - base_done, 1);
    checkOutput({name, "_done_cycle"}, done_cyc,
                (rx_cyc_q.size() > 0) ? rx_cyc_q[rx_cyc_q.size() - 1] + 1 : -100);
    checkOutput({name, "_busy_after"}, busy, 0);
  endtask

  task automatic check_stream(input string name);
    logic [7:0] exp_q[$];
    int bad   = 0;
    int first = -1;
    for (int a = 0; a < DEPTH; a++) begin
      exp_q.push_back((exp_mem[a] == 8'h00) ? FILL : exp_mem[a]);
      if (NL_ON && (a % ROW_LEN) == ROW_LEN - 1) exp_q.push_back(8'h0A);
    end
    checkOutput({name, "_count"}, rx_q.size() - base_rx, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base_rx + i >= rx_q.size() || rx_q[base_rx + i] !== exp_q[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    if (first >= 0) $display("[TB] %s first differing byte at index %0d", name, first);
    checkOutput({name, "_bytes_bad"}, bad, 0);
  endtask

  mux_vec_t vecs[6];

  initial begin
    int n;
    int bad;
    int rx_before;

    rst = 1'b1; start = 1'b0; ed_we = 1'b0; ed_addr = '0; ed_wdata = 8'h00; tx_ready = 1'b0;
    for (int a = 0; a < DEPTH; a++) ram[a] = 8'h00;
    tick();
    tick();
    checkOutput("rst_tx_valid", tx_valid, 0);
    checkOutput("rst_tx_data", tx_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    tick();

    // Combinational port mux while idle (rd_ptr is 0).
    vecs[0] = '{we: 1'b0, addr: 9'd17,  wdata: 8'hAA, exp_addr: 9'd0,   exp_we: 1'b0, exp_wdata: 8'h00};
    vecs[1] = '{we: 1'b1, addr: 9'd17,  wdata: 8'hAA, exp_addr: 9'd17,  exp_we: 1'b1, exp_wdata: 8'hAA};
    vecs[2] = '{we: 1'b1, addr: 9'd511, wdata: 8'hFF, exp_addr: 9'd511, exp_we: 1'b1, exp_wdata: 8'hFF};
    vecs[3] = '{we: 1'b1, addr: 9'd0,   wdata: 8'h01, exp_addr: 9'd0,   exp_we: 1'b1, exp_wdata: 8'h01};
    vecs[4] = '{we: 1'b0, addr: 9'd300, wdata: 8'h55, exp_addr: 9'd0,   exp_we: 1'b0, exp_wdata: 8'h00};
    vecs[5] = '{we: 1'b1, addr: 9'd256, wdata: 8'h80, exp_addr: 9'd256, exp_we: 1'b1, exp_wdata: 8'h80};
    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);
    ed_we = 1'b0;
    checkOutput("idle_busy", busy, 0);
    tick();

    $display("[TB] basic dump");
    ram[0] = 8'h41; ram[1] = 8'h42; ram[2] = 8'h00; ram[3] = 8'h43;
    tx_ready = 1'b1;
    start_dump();
    checkOutput("lat_c1_valid", tx_valid, 0);
    checkOutput("lat_c1_busy", busy, 1);
    tick();
    checkOutput("lat_c2_valid", tx_valid, 1);
    checkOutput("lat_c2_data", tx_data, 8'h41);
    run_to_done("basic", 3000, 1'b0);
    checkOutput("basic_b0", rx_q[base_rx + 0], 8'h41);
    checkOutput("basic_b1", rx_q[base_rx + 1], 8'h42);
    checkOutput("basic_b2", rx_q[base_rx + 2], 8'h20);
    checkOutput("basic_b3", rx_q[base_rx + 3], 8'h43);
    check_stream("basic");

    $display("[TB] backpressure");
    tx_ready = 1'b0;
    start_dump();
    wait_valid("bp0", 10);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    wait_valid("bp1", 10);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_valid !== 1'b1 || tx_data !== 8'h42) bad++;
      tick();
    end
    checkOutput("bp_hold_bad", bad, 0);
    tx_ready = 1'b1;
    run_to_done("bp", 3000, 1'b0);
    check_stream("bp");

    $display("[TB] collision");
    ram[5] = 8'h33;
    tx_ready = 1'b0;
    start_dump();
    for (int k = 0; k < 5; k++) begin
      wait_valid($sformatf("col_hs%0d", k), 10);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
    end
    ed_we = 1'b1; ed_addr = 9'd5; ed_wdata = 8'h5A;
    exp_mem[5] = 8'h5A;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput($sformatf("col%0d_mem_we", c), mem_we, 1);
      checkOutput($sformatf("col%0d_mem_addr", c), mem_addr, 5);
      checkOutput($sformatf("col%0d_stalled", c), tx_valid, 0);
      tick();
    end
    ed_we = 1'b0;
    wait_valid("col_after", 10);
    checkOutput("col_data", tx_data, 8'h5A);
    tx_ready = 1'b1;
    run_to_done("col", 3000, 1'b0);
    check_stream("col");

    $display("[TB] start while busy");
    tx_ready = 1'b1;
    start_dump();
    n = 0;
    while (sent_addrs(rx_q.size() - base_rx) < 200 && n < 1000) begin
      tick();
      n++;
    end
    checkOutput("bs_reached_200", sent_addrs(rx_q.size() - base_rx) >= 200, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_done("bs", 3000, 1'b0);
    check_stream("bs");

    $display("[TB] reset mid-dump");
    tx_ready = 1'b1;
    start_dump();
    n = 0;
    while (rx_q.size() - base_rx < 100 && n < 1000) begin
      tick();
      n++;
    end
    tx_ready = 1'b0;
    wait_valid("mr", 10);
    rst = 1'b1;
    #1;
    checkOutput("mr_tx_valid", tx_valid, 0);
    checkOutput("mr_busy", busy, 0);
    checkOutput("mr_done", done, 0);
    tick();
    tick();
    rst = 1'b0;
    rx_before = rx_q.size();
    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    checkOutput("mr_no_more_bytes", rx_q.size() - rx_before, 0);
    checkOutput("mr_idle_busy", busy, 0);

    for (int it = 0; it < 2; it++) begin
      $display("[TB] random dump %0d", it);
      for (int a = 0; a < DEPTH; a++)
        ram[a] = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      rand_ready = 1'b1;
      start_dump();
      run_to_done($sformatf("rnd%0d", it), 8000, 1'b1);
      rand_ready = 1'b0;
      check_stream($sformatf("rnd%0d", it));
    end

    checkOutput("done_valid_overlap", overlap_cnt, 0);
    checkOutput("stall_unstable", unstable_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got hang, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
